// File: rtl/alu_operand_dispatch.sv
// Decode/dispatch stage: decodes MIPS words, reads the register file with write-back bypass,
// stalls read-after-write hazards through a busy scoreboard and registers the ALU operands.
module alu_operand_dispatch #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR_W    = 5,
  parameter bit SCOREBOARD_EN = 1'b1
) (
  input  logic                  ClockInput,
  input  logic                  ResetInput,
  input  logic                  InstrValid,
  input  logic [31:0]           InstrWord,
  output logic                  InstrReady,
  input  logic                  WriteBackEnable,
  input  logic [REG_ADDR_W-1:0] WriteBackAddress,
  input  logic [DATA_WIDTH-1:0] WriteBackData,
  output logic [DATA_WIDTH-1:0] PriOperand,
  output logic [DATA_WIDTH-1:0] SecOperand,
  output logic [DATA_WIDTH-1:0] OFFSETOperand,
  output logic                  AddressCalculateSignal,
  output logic [3:0]            Function,
  output logic [REG_ADDR_W-1:0] DestAddress,
  output logic                  DestWrite,
  output logic                  DispatchValid,
  output logic                  IllegalInstr
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  typedef enum logic [3:0] {
    FN_ADD = 4'd0,
    FN_SUB = 4'd1,
    FN_AND = 4'd2,
    FN_OR  = 4'd3,
    FN_XOR = 4'd4
  } aluFuncT;

  typedef struct packed {
    logic    legal;
    logic    usesRs;
    logic    usesRt;
    logic    addrCalc;
    logic    zeroExt;
    logic    destIsRd;
    logic    writesDest;
    aluFuncT func;
  } decodeT;

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] rsAddr;
  logic [REG_ADDR_W-1:0] rtAddr;
  logic [REG_ADDR_W-1:0] rdAddr;
  logic [15:0]           imm;
  logic                  unusedShamt;

  assign opcode      = InstrWord[31:26];
  assign rsAddr      = InstrWord[21 +: REG_ADDR_W];
  assign rtAddr      = InstrWord[16 +: REG_ADDR_W];
  assign rdAddr      = InstrWord[11 +: REG_ADDR_W];
  assign funct       = InstrWord[5:0];
  assign imm         = InstrWord[15:0];
  assign unusedShamt = ^InstrWord[10:6];

  decodeT dec;

  // NOTE: every field gets a default first so a missed decode case cannot infer a latch.
  always_comb begin
    dec = '{legal: 1'b0, usesRs: 1'b0, usesRt: 1'b0, addrCalc: 1'b0, zeroExt: 1'b0,
            destIsRd: 1'b0, writesDest: 1'b0, func: FN_ADD};
    unique case (opcode)
      6'h00: begin
        dec.usesRs     = 1'b1;
        dec.usesRt     = 1'b1;
        dec.destIsRd   = 1'b1;
        dec.writesDest = 1'b1;
        dec.legal      = 1'b1;
        unique case (funct)
          6'h20, 6'h21: dec.func = FN_ADD;
          6'h22, 6'h23: dec.func = FN_SUB;
          6'h24:        dec.func = FN_AND;
          6'h25:        dec.func = FN_OR;
          6'h26:        dec.func = FN_XOR;
          default: begin
            dec.legal  = 1'b0;
            dec.usesRs = 1'b0;
            dec.usesRt = 1'b0;
          end
        endcase
      end
      6'h08, 6'h09, 6'h23: begin
        dec = '{legal: 1'b1, usesRs: 1'b1, usesRt: 1'b0, addrCalc: 1'b1, zeroExt: 1'b0,
                destIsRd: 1'b0, writesDest: 1'b1, func: FN_ADD};
      end
      6'h0C, 6'h0D, 6'h0E: begin
        dec = '{legal: 1'b1, usesRs: 1'b1, usesRt: 1'b0, addrCalc: 1'b1, zeroExt: 1'b1,
                destIsRd: 1'b0, writesDest: 1'b1, func: FN_AND};
        if (opcode == 6'h0D) dec.func = FN_OR;
        if (opcode == 6'h0E) dec.func = FN_XOR;
      end
      6'h2B: begin
        dec = '{legal: 1'b1, usesRs: 1'b1, usesRt: 1'b1, addrCalc: 1'b1, zeroExt: 1'b0,
                destIsRd: 1'b0, writesDest: 1'b0, func: FN_ADD};
      end
      6'h04: begin
        dec = '{legal: 1'b1, usesRs: 1'b1, usesRt: 1'b1, addrCalc: 1'b0, zeroExt: 1'b0,
                destIsRd: 1'b0, writesDest: 1'b0, func: FN_SUB};
      end
      default: dec.legal = 1'b0;
    endcase
  end

  // Destination resolution; writes aimed at r0 are squashed so r0 never turns busy.
  logic [REG_ADDR_W-1:0] destAddr;
  logic                  destWriteEff;
  logic [DATA_WIDTH-1:0] immExt;

  always_comb begin
    destAddr = '0;
    if (dec.writesDest) destAddr = dec.destIsRd ? rdAddr : rtAddr;
    destWriteEff = dec.writesDest && (destAddr != '0);
    immExt = dec.zeroExt ? {{(DATA_WIDTH-16){1'b0}}, imm}
                         : {{(DATA_WIDTH-16){imm[15]}}, imm};
  end

  logic [DATA_WIDTH-1:0] regFile [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busyNext;
  logic [DATA_WIDTH-1:0] rsData;
  logic [DATA_WIDTH-1:0] rtData;
  logic                  rsHazard;
  logic                  rtHazard;
  logic                  accept;

  // Register read with same-cycle write-back bypass; r0 is hard-wired to zero.
  always_comb begin
    rsData = regFile[rsAddr];
    rtData = regFile[rtAddr];
    if (WriteBackEnable && WriteBackAddress == rsAddr) rsData = WriteBackData;
    if (WriteBackEnable && WriteBackAddress == rtAddr) rtData = WriteBackData;
    if (rsAddr == '0) rsData = '0;
    if (rtAddr == '0) rtData = '0;
  end

  // A busy source is released by a write-back to it in the very same cycle.
  always_comb begin
    rsHazard = dec.usesRs && busy[rsAddr] && !(WriteBackEnable && WriteBackAddress == rsAddr);
    rtHazard = dec.usesRt && busy[rtAddr] && !(WriteBackEnable && WriteBackAddress == rtAddr);
    InstrReady = SCOREBOARD_EN ? !(rsHazard || rtHazard) : 1'b1;
    accept = InstrValid && InstrReady;
  end

  // Clear on write-back first, then set on dispatch, so a same-cycle set wins.
  always_comb begin
    busyNext = busy;
    if (WriteBackEnable) busyNext[WriteBackAddress] = 1'b0;
    if (accept && dec.legal && destWriteEff) busyNext[destAddr] = 1'b1;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge ClockInput) begin
    if (ResetInput) begin
      PriOperand             <= '0;
      SecOperand             <= '0;
      OFFSETOperand          <= '0;
      AddressCalculateSignal <= 1'b0;
      Function               <= '0;
      DestAddress            <= '0;
      DestWrite              <= 1'b0;
      DispatchValid          <= 1'b0;
      IllegalInstr           <= 1'b0;
      busy                   <= '0;
    end else begin
      DispatchValid <= 1'b0;
      DestWrite     <= 1'b0;
      IllegalInstr  <= 1'b0;
      busy          <= busyNext;
      if (accept) begin
        if (dec.legal) begin
          PriOperand             <= rsData;
          SecOperand             <= rtData;
          OFFSETOperand          <= immExt;
          AddressCalculateSignal <= dec.addrCalc;
          Function               <= dec.func;
          DestAddress            <= destAddr;
          DestWrite              <= destWriteEff;
          DispatchValid          <= 1'b1;
        end else begin
          IllegalInstr <= 1'b1;
        end
      end
    end
  end

  // NOTE: the register file is reset on purpose -- architecturally every register reads 0
  // after reset, so this memory is built from flops rather than an uninitialised RAM.
  always_ff @(posedge ClockInput) begin
    if (ResetInput) begin
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
    end else if (WriteBackEnable && WriteBackAddress != '0) begin
      regFile[WriteBackAddress] <= WriteBackData;
    end
  end

endmodule

// File: tb/tb_alu_operand_dispatch.sv
// Directed bench for alu_operand_dispatch: decode, operand read, bypass, RAW stall, reset.
module tb_alu_operand_dispatch;

  logic        ClockInput;
  logic        ResetInput;
  logic        InstrValid;
  logic [31:0] InstrWord;
  logic        InstrReady;
  logic        WriteBackEnable;
  logic [4:0]  WriteBackAddress;
  logic [31:0] WriteBackData;
  logic [31:0] PriOperand;
  logic [31:0] SecOperand;
  logic [31:0] OFFSETOperand;
  logic        AddressCalculateSignal;
  logic [3:0]  Function;
  logic [4:0]  DestAddress;
  logic        DestWrite;
  logic        DispatchValid;
  logic        IllegalInstr;

  int errors = 0;
  int checks = 0;

  alu_operand_dispatch #(.DATA_WIDTH(32), .REG_ADDR_W(5), .SCOREBOARD_EN(1'b1)) dut (
    .ClockInput(ClockInput), .ResetInput(ResetInput),
    .InstrValid(InstrValid), .InstrWord(InstrWord), .InstrReady(InstrReady),
    .WriteBackEnable(WriteBackEnable), .WriteBackAddress(WriteBackAddress),
    .WriteBackData(WriteBackData),
    .PriOperand(PriOperand), .SecOperand(SecOperand), .OFFSETOperand(OFFSETOperand),
    .AddressCalculateSignal(AddressCalculateSignal), .Function(Function),
    .DestAddress(DestAddress), .DestWrite(DestWrite),
    .DispatchValid(DispatchValid), .IllegalInstr(IllegalInstr)
  );

  initial ClockInput = 1'b0;
  always #5 ClockInput = ~ClockInput;

  // Inputs change and outputs are sampled on the negedge, away from the active posedge.
  task automatic do_wb(input logic [4:0] addr, input logic [31:0] data);
    WriteBackEnable = 1'b1; WriteBackAddress = addr; WriteBackData = data;
    @(negedge ClockInput);
    WriteBackEnable = 1'b0;
  endtask

  task automatic issue(input logic [31:0] word);
    InstrValid = 1'b1; InstrWord = word;
    @(negedge ClockInput);
    InstrValid = 1'b0;
  endtask

  task automatic test_reset;
    ResetInput = 1'b1;
    repeat (2) @(negedge ClockInput);
    ResetInput = 1'b0;
    checks++; if (PriOperand !== 32'd0) begin errors++; $display("FAIL rst_pri got=%h exp=0", PriOperand); end
    checks++; if (SecOperand !== 32'd0) begin errors++; $display("FAIL rst_sec got=%h exp=0", SecOperand); end
    checks++; if (OFFSETOperand !== 32'd0) begin errors++; $display("FAIL rst_off got=%h exp=0", OFFSETOperand); end
    checks++; if (AddressCalculateSignal !== 1'b0) begin errors++; $display("FAIL rst_ac got=%b exp=0", AddressCalculateSignal); end
    checks++; if (Function !== 4'd0) begin errors++; $display("FAIL rst_fn got=%h exp=0", Function); end
    checks++; if (DestAddress !== 5'd0) begin errors++; $display("FAIL rst_dest got=%h exp=0", DestAddress); end
    checks++; if (DestWrite !== 1'b0) begin errors++; $display("FAIL rst_dw got=%b exp=0", DestWrite); end
    checks++; if (DispatchValid !== 1'b0) begin errors++; $display("FAIL rst_dv got=%b exp=0", DispatchValid); end
    checks++; if (IllegalInstr !== 1'b0) begin errors++; $display("FAIL rst_ill got=%b exp=0", IllegalInstr); end
    checks++; if (InstrReady !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", InstrReady); end
  endtask

  task automatic test_rtype;
    do_wb(5'd1, 32'd5);
    do_wb(5'd2, 32'd3);
    issue(32'h0022_1820);  // add r3,r1,r2
    checks++; if (PriOperand !== 32'd5) begin errors++; $display("FAIL add_pri got=%h exp=5", PriOperand); end
    checks++; if (SecOperand !== 32'd3) begin errors++; $display("FAIL add_sec got=%h exp=3", SecOperand); end
    checks++; if (Function !== 4'd0) begin errors++; $display("FAIL add_fn got=%h exp=0", Function); end
    checks++; if (AddressCalculateSignal !== 1'b0) begin errors++; $display("FAIL add_ac got=%b exp=0", AddressCalculateSignal); end
    checks++; if (DestAddress !== 5'd3) begin errors++; $display("FAIL add_dest got=%h exp=3", DestAddress); end
    checks++; if (DestWrite !== 1'b1) begin errors++; $display("FAIL add_dw got=%b exp=1", DestWrite); end
    checks++; if (DispatchValid !== 1'b1) begin errors++; $display("FAIL add_dv got=%b exp=1", DispatchValid); end
    @(negedge ClockInput);
    checks++; if (DispatchValid !== 1'b0) begin errors++; $display("FAIL idle_dv got=%b exp=0", DispatchValid); end
    checks++; if (DestWrite !== 1'b0) begin errors++; $display("FAIL idle_dw got=%b exp=0", DestWrite); end
    checks++; if (PriOperand !== 32'd5) begin errors++; $display("FAIL idle_pri_hold got=%h exp=5", PriOperand); end
    do_wb(5'd3, 32'd8);
  endtask

  task automatic test_itype;
    issue(32'h8C24_FFFC);  // lw r4,-4(r1)
    checks++; if (PriOperand !== 32'd5) begin errors++; $display("FAIL lw_pri got=%h exp=5", PriOperand); end
    checks++; if (OFFSETOperand !== 32'hFFFF_FFFC) begin errors++; $display("FAIL lw_off got=%h exp=fffffffc", OFFSETOperand); end
    checks++; if (AddressCalculateSignal !== 1'b1) begin errors++; $display("FAIL lw_ac got=%b exp=1", AddressCalculateSignal); end
    checks++; if (Function !== 4'd0) begin errors++; $display("FAIL lw_fn got=%h exp=0", Function); end
    checks++; if (DestAddress !== 5'd4 || DestWrite !== 1'b1) begin errors++; $display("FAIL lw_dest got=%h/%b exp=4/1", DestAddress, DestWrite); end
    issue(32'h3405_8000);  // ori r5,r0,0x8000
    checks++; if (OFFSETOperand !== 32'h0000_8000) begin errors++; $display("FAIL ori_off got=%h exp=00008000", OFFSETOperand); end
    checks++; if (Function !== 4'd3) begin errors++; $display("FAIL ori_fn got=%h exp=3", Function); end
    checks++; if (PriOperand !== 32'd0) begin errors++; $display("FAIL ori_pri got=%h exp=0", PriOperand); end
    checks++; if (DestAddress !== 5'd5 || AddressCalculateSignal !== 1'b1) begin errors++; $display("FAIL ori_dest got=%h/%b exp=5/1", DestAddress, AddressCalculateSignal); end
    issue(32'h2026_FFFF);  // addi r6,r1,-1
    checks++; if (OFFSETOperand !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_off got=%h exp=ffffffff", OFFSETOperand); end
    checks++; if (DestAddress !== 5'd6 || Function !== 4'd0) begin errors++; $display("FAIL addi_dest got=%h/%h exp=6/0", DestAddress, Function); end
    issue(32'hAC22_0008);  // sw r2,8(r1)
    checks++; if (DestWrite !== 1'b0 || DispatchValid !== 1'b1) begin errors++; $display("FAIL sw_dw got=%b/%b exp=0/1", DestWrite, DispatchValid); end
    checks++; if (OFFSETOperand !== 32'd8 || SecOperand !== 32'd3) begin errors++; $display("FAIL sw_ops got=%h/%h exp=8/3", OFFSETOperand, SecOperand); end
    issue(32'h1022_0010);  // beq r1,r2,0x10
    checks++; if (Function !== 4'd1 || AddressCalculateSignal !== 1'b0) begin errors++; $display("FAIL beq_fn got=%h/%b exp=1/0", Function, AddressCalculateSignal); end
    checks++; if (DestWrite !== 1'b0) begin errors++; $display("FAIL beq_dw got=%b exp=0", DestWrite); end
    checks++; if (PriOperand !== 32'd5 || SecOperand !== 32'd3) begin errors++; $display("FAIL beq_ops got=%h/%h exp=5/3", PriOperand, SecOperand); end
    issue(32'h0022_3826);  // xor r7,r1,r2
    checks++; if (Function !== 4'd4 || DestAddress !== 5'd7) begin errors++; $display("FAIL xor_fn got=%h/%h exp=4/7", Function, DestAddress); end
    checks++; if (DestWrite !== 1'b1 || AddressCalculateSignal !== 1'b0) begin errors++; $display("FAIL xor_dw got=%b/%b exp=1/0", DestWrite, AddressCalculateSignal); end
    do_wb(5'd4, 32'h11);
    do_wb(5'd5, 32'h8000);
    do_wb(5'd6, 32'h66);
    do_wb(5'd7, 32'd6);
  endtask

  task automatic test_illegal;
    issue(32'h0022_1820);  // add r3,r1,r2 -> r3 busy
    issue(32'hFC00_0000);  // opcode 0x3F
    checks++; if (IllegalInstr !== 1'b1) begin errors++; $display("FAIL ill_pulse got=%b exp=1", IllegalInstr); end
    checks++; if (DispatchValid !== 1'b0 || DestWrite !== 1'b0) begin errors++; $display("FAIL ill_dv got=%b/%b exp=0/0", DispatchValid, DestWrite); end
    @(negedge ClockInput);
    checks++; if (IllegalInstr !== 1'b0) begin errors++; $display("FAIL ill_one_cycle got=%b exp=0", IllegalInstr); end
    InstrValid = 1'b1; InstrWord = 32'h0061_3022;  // sub r6,r3,r1: r3 still busy
    #1;
    checks++; if (InstrReady !== 1'b0) begin errors++; $display("FAIL ill_busy_kept got=%b exp=0", InstrReady); end
    InstrValid = 1'b0;
    issue(32'h0022_5027);  // funct 0x27 unsupported, rd=r10
    checks++; if (IllegalInstr !== 1'b1) begin errors++; $display("FAIL ill_funct got=%b exp=1", IllegalInstr); end
    InstrValid = 1'b1; InstrWord = 32'h0141_5820;  // add r11,r10,r1: r10 must not be busy
    #1;
    checks++; if (InstrReady !== 1'b1) begin errors++; $display("FAIL ill_no_busy_rd got=%b exp=1", InstrReady); end
    InstrValid = 1'b0;
    do_wb(5'd0, 32'h0000_DEAD);
    issue(32'h0022_0020);  // add r0,r1,r2
    checks++; if (DispatchValid !== 1'b1 || DestWrite !== 1'b0) begin errors++; $display("FAIL r0_dw got=%b/%b exp=1/0", DispatchValid, DestWrite); end
    InstrValid = 1'b1; InstrWord = 32'h0001_6020;  // add r12,r0,r1
    #1;
    checks++; if (InstrReady !== 1'b1) begin errors++; $display("FAIL r0_no_stall got=%b exp=1", InstrReady); end
    @(negedge ClockInput);
    InstrValid = 1'b0;
    checks++; if (PriOperand !== 32'd0 || SecOperand !== 32'd5) begin errors++; $display("FAIL r0_read got=%h/%h exp=0/5", PriOperand, SecOperand); end
    checks++; if (DestAddress !== 5'd12 || DestWrite !== 1'b1) begin errors++; $display("FAIL r12_dest got=%h/%b exp=c/1", DestAddress, DestWrite); end
    do_wb(5'd12, 32'd5);
    do_wb(5'd3, 32'd8);
  endtask

  task automatic test_stall;
    int bad;
    issue(32'h0022_1820);  // add r3 -> r3 busy
    InstrValid = 1'b1; InstrWord = 32'h0061_3022;  // sub r6,r3,r1
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (InstrReady !== 1'b0) bad++;
      @(negedge ClockInput);
      if (DispatchValid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold got=%0d exp=0 bad cycles", bad); end
    WriteBackEnable = 1'b1; WriteBackAddress = 5'd3; WriteBackData = 32'd8;
    #1;
    checks++; if (InstrReady !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", InstrReady); end
    @(negedge ClockInput);
    InstrValid = 1'b0; WriteBackEnable = 1'b0;
    checks++; if (DispatchValid !== 1'b1) begin errors++; $display("FAIL sub_dv got=%b exp=1", DispatchValid); end
    checks++; if (PriOperand !== 32'd8) begin errors++; $display("FAIL sub_bypass got=%h exp=8", PriOperand); end
    checks++; if (SecOperand !== 32'd5 || Function !== 4'd1 || DestAddress !== 5'd6) begin errors++; $display("FAIL sub_ops got=%h/%h/%h exp=5/1/6", SecOperand, Function, DestAddress); end
    InstrValid = 1'b1; InstrWord = 32'h0061_3022;  // reads r3 again: must be free now
    #1;
    checks++; if (InstrReady !== 1'b1) begin errors++; $display("FAIL busy3_clear got=%b exp=1", InstrReady); end
    InstrValid = 1'b1; InstrWord = 32'h00C1_4820;  // add r9,r6,r1: r6 busy, no write-back
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge ClockInput);
      if (InstrReady !== 1'b0 || DispatchValid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_200 got=%0d exp=0 bad cycles", bad); end
  endtask

  task automatic test_reset_mid_stall;
    ResetInput = 1'b1;
    @(negedge ClockInput);
    ResetInput = 1'b0;
    checks++; if (PriOperand !== 32'd0 || SecOperand !== 32'd0 || OFFSETOperand !== 32'd0) begin errors++; $display("FAIL mrst_ops got=%h/%h/%h exp=0/0/0", PriOperand, SecOperand, OFFSETOperand); end
    checks++; if (Function !== 4'd0 || DestAddress !== 5'd0 || AddressCalculateSignal !== 1'b0) begin errors++; $display("FAIL mrst_ctl got=%h/%h/%b exp=0/0/0", Function, DestAddress, AddressCalculateSignal); end
    checks++; if (DispatchValid !== 1'b0 || DestWrite !== 1'b0 || IllegalInstr !== 1'b0) begin errors++; $display("FAIL mrst_flags got=%b/%b/%b exp=0/0/0", DispatchValid, DestWrite, IllegalInstr); end
    #1;
    checks++; if (InstrReady !== 1'b1) begin errors++; $display("FAIL mrst_ready got=%b exp=1", InstrReady); end
    InstrValid = 1'b0;
    @(negedge ClockInput);
    checks++; if (DispatchValid !== 1'b0) begin errors++; $display("FAIL mrst_dropped got=%b exp=0", DispatchValid); end
    issue(32'h0022_1820);  // add r3,r1,r2 after register file cleared
    checks++; if (DispatchValid !== 1'b1 || PriOperand !== 32'd0 || SecOperand !== 32'd0) begin errors++; $display("FAIL mrst_rf got=%b/%h/%h exp=1/0/0", DispatchValid, PriOperand, SecOperand); end
  endtask

  initial begin
    ResetInput = 1'b1; InstrValid = 1'b0; InstrWord = '0;
    WriteBackEnable = 1'b0; WriteBackAddress = '0; WriteBackData = '0;
    test_reset();
    test_rtype();
    test_itype();
    test_illegal();
    test_stall();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
